if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
- Instruction fetch stage that sits directly upstream of the control unit.
- Holds the PC and fetches 32-bit instructions from a word-addressed instruction memory using a req/ack handshake with variable latency.
- Presents the captured instruction to decode/control with a valid flag.
- Advances the PC only when control asserts PC_LdEn: sequential PC+4 when PC_Sel=0, branch target when PC_Sel=1.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset; bits [1:0] must be 0.
- IMEM_AW, 10, instruction-memory word-address width.
- TIMEOUT, 16, max ack wait in cycles; used only with IF_TIMEOUT_EN.

Ports:
- Clk  input  1  clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- PC_Sel  input  1  from control: 0 = PC+4, 1 = branch target.
- PC_LdEn  input  1  from control: advance PC, consume current Instr.
- PC_Immed  input  16  branch offset in words, signed (Instr[15:0] of current instruction).
- imem_req  output  1  instruction-memory read request.
- imem_addr  output  IMEM_AW  word address = PC[IMEM_AW+1:2].
- imem_rdata  input  32  read data, valid when imem_ack=1.
- imem_ack  input  1  read complete; may be high in the same cycle as imem_req.
- Instr  output  32  captured instruction, to control/decode.
- Instr_valid  output  1  Instr holds the instruction at PC.
- PC  output  32  current PC.
- Fetch_err  output  1  sticky timeout flag; tied 0 without IF_TIMEOUT_EN.

Behaviour:
- Reset (Reset=0, async):
  - PC=RESET_PC, Instr=0, Instr_valid=0, imem_req=0, Fetch_err=0.
  - State=FETCH; the wait counter is cleared.
  - imem_ack and PC_LdEn are ignored while Reset=0.
  - The first request is issued in the first cycle after Reset deasserts.
- State FETCH:
  - imem_req=1 combinationally; imem_addr=PC[IMEM_AW+1:2]; Instr_valid=0.
  - On imem_ack=1 at a rising edge: Instr<=imem_rdata, Instr_valid<=1, go to HOLD.
  - PC_LdEn is ignored in FETCH, including when ack and PC_LdEn arrive in the same cycle.
- State HOLD:
  - imem_req=0; Instr and Instr_valid=1 are held stable.
  - On PC_LdEn=1 at a rising edge: PC<=next_pc, Instr_valid<=0, go to FETCH.
  - Instr keeps its old value until the next ack; consumers must qualify it with Instr_valid.
  - imem_ack in HOLD is ignored.
- next_pc (combinational, computed from PC at the edge):
  - PC_Sel=0: PC+4.
  - PC_Sel=1: PC+4+(sign_extend(PC_Immed)<<2).
  - Arithmetic is 32-bit, modulo 2^32; wrap-around is silent (32'hFFFF_FFFC+4 = 0).
- Latency:
  - One instruction takes at least 2 cycles: a FETCH cycle with same-cycle ack, then a HOLD cycle with PC_LdEn.
  - Each extra cycle without ack adds one cycle.
- Reset mid-request: imem_req drops asynchronously; any ack arriving later is not captured until the new FETCH.
- PC[1:0] stays 0 at all times, since updates are only +4 and word-scaled offsets.

Optional Feature:
- Macro: IF_TIMEOUT_EN.
- Defined:
  - A counter increments each FETCH cycle with imem_ack=0 and clears on ack or on reset.
  - When it reaches TIMEOUT: Fetch_err<=1 (sticky until reset), the counter clears, and imem_req drops for exactly one cycle before re-requesting the same address.
  - The PC is unchanged by a timeout.
- Not defined: no counter logic; Fetch_err is tied to 0; FETCH waits indefinitely.

Test Plan:
- Reset release, RESET_PC=0, memory acks same cycle with 32'h8000_0003:
  - Cycle 1: imem_req=1, imem_addr=0.
  - Cycle 2: Instr=32'h8000_0003, Instr_valid=1.
  - PC_LdEn=1, PC_Sel=0 → PC=4, Instr_valid=0, next request at addr 1.
- Ack delayed 3 cycles:
  - imem_req stays 1 and Instr_valid stays 0 for 3 cycles.
  - Instr is captured on the 4th cycle.
  - PC_LdEn asserted during the wait has no effect (PC unchanged).
- Branch from PC=32'h0000_0010 with PC_Sel=1:
  - PC_Immed=16'h0003 → PC=32'h0000_0020.
  - PC_Immed=16'hFFFC → PC=32'h0000_0004.
- Wrap: PC=32'hFFFF_FFFC, PC_Sel=0, PC_LdEn=1 → PC=0, imem_addr=0.
- Async reset pulled low mid-FETCH at PC=8 (between edges):
  - imem_req=0, PC=RESET_PC, Instr_valid=0 immediately, without waiting for an edge.
  - A subsequent ack is ignored.
- IF_TIMEOUT_EN defined, TIMEOUT=16, no ack:
  - Fetch_err rises after 16 wait cycles.
  - imem_req is low for 1 cycle, then re-requests the same address.
  - A later ack captures normally; Fetch_err stays 1 until reset.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: holds the PC, fetches over a req/ack handshake and hands the word to decode.
// Optional macro IF_TIMEOUT_EN adds a fetch-wait watchdog with a sticky Fetch_err flag.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 10,
    parameter int          TIMEOUT  = 16
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               PC_Sel,
    input  logic               PC_LdEn,
    input  logic [15:0]        PC_Immed,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    input  logic               imem_ack,
    output logic [31:0]        Instr,
    output logic               Instr_valid,
    output logic [31:0]        PC,
    output logic               Fetch_err
);

    if (TIMEOUT < 1 || RESET_PC[1:0] != 2'b00) begin : g_param_check
        $error("if_fetch_stage: TIMEOUT must be >= 1 and RESET_PC word aligned");
    end

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic [31:0] next_pc;
    logic        req_gap;

    // Offset is in words, so it is scaled by 4 before the add; wrap is modulo 2^32.
    always_comb begin
        next_pc = pc_q + 32'd4 + (PC_Sel ? {{14{PC_Immed[15]}}, PC_Immed, 2'b00} : 32'd0);
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        case (state_q)
            FETCH: begin
                if (imem_ack && !req_gap) begin
                    instr_d = imem_rdata;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (PC_LdEn) begin
                    pc_d    = next_pc;
                    valid_d = 1'b0;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

`ifdef IF_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             gap_q, gap_d;
    logic             err_q, err_d;

    // The request is withdrawn for one cycle after a timeout, then the same address is retried.
    always_comb begin
        cnt_d = cnt_q;
        gap_d = 1'b0;
        err_d = err_q;
        if (!gap_q && state_q == FETCH) begin
            if (imem_ack) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                cnt_d = '0;
                gap_d = 1'b1;
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt_q <= '0;
            gap_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            gap_q <= gap_d;
            err_q <= err_d;
        end
    end

    assign req_gap   = gap_q;
    assign Fetch_err = err_q;
`else
    assign req_gap   = 1'b0;
    assign Fetch_err = 1'b0;
`endif

    // Gated with Reset so the request drops the moment reset asserts, not at the next edge.
    assign imem_req    = Reset && (state_q == FETCH) && !req_gap;
    assign imem_addr   = pc_q[IMEM_AW+1:2];
    assign Instr       = instr_q;
    assign Instr_valid = valid_q;
    assign PC          = pc_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios followed by randomized traffic against a reference model.
module tb_if_fetch_stage;
    localparam int TIMEOUT = 16;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        PC_Sel;
    logic        PC_LdEn;
    logic [15:0] PC_Immed;
    logic        imem_req;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic [31:0] Instr;
    logic        Instr_valid;
    logic [31:0] PC;
    logic        Fetch_err;

    if_fetch_stage #(.RESET_PC(32'h0), .IMEM_AW(10), .TIMEOUT(TIMEOUT)) dut (
        .Clk(Clk), .Reset(Reset), .PC_Sel(PC_Sel), .PC_LdEn(PC_LdEn), .PC_Immed(PC_Immed),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
        .Instr(Instr), .Instr_valid(Instr_valid), .PC(PC), .Fetch_err(Fetch_err)
    );

    always #5 Clk = ~Clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem [1024];

    // Reference model: "waiting for a word" vs "holding a word", plus watchdog bookkeeping.
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic        m_valid;
    logic        m_waiting;
    logic        m_err;
    logic        m_gap;
    int          m_nack_run;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h0; m_valid = 1'b0; m_waiting = 1'b1;
        m_err = 1'b0; m_gap = 1'b0; m_nack_run = 0;
    endtask

    task automatic cycle(input logic ack, input logic ld, input logic sel, input logic [15:0] imm);
        logic [31:0] rd;
        logic        exp_req;
        int          off;
        @(negedge Clk);
        rd = ack ? mem[m_pc[11:2]] : $urandom;
        PC_Sel = sel; PC_LdEn = ld; PC_Immed = imm; imem_ack = ack; imem_rdata = rd;
        #1;
        exp_req = m_waiting && !m_gap;
        chk("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
        if (exp_req) chk("imem_addr", {22'd0, imem_addr}, {22'd0, m_pc[11:2]});
        @(posedge Clk);
        #1;
        if (m_gap) begin
            m_gap = 1'b0;
        end else if (m_waiting) begin
            if (ack) begin
                m_instr = rd; m_valid = 1'b1; m_waiting = 1'b0; m_nack_run = 0;
            end else begin
`ifdef IF_TIMEOUT_EN
                m_nack_run++;
                if (m_nack_run == TIMEOUT) begin
                    m_nack_run = 0; m_err = 1'b1; m_gap = 1'b1;
                end
`endif
            end
        end else if (ld) begin
            off = int'($signed(imm));
            m_pc = m_pc + 32'd4 + (sel ? 32'(off * 4) : 32'd0);
            m_valid = 1'b0; m_waiting = 1'b1;
        end
        chk("PC", PC, m_pc);
        chk("Instr", Instr, m_instr);
        chk("Instr_valid", {31'd0, Instr_valid}, {31'd0, m_valid});
        chk("Fetch_err", {31'd0, Fetch_err}, {31'd0, m_err});
        $display("[TB] t=%0t ack=%0b ld=%0b sel=%0b imm=%h -> PC=%h valid=%0b Instr=%h err=%0b",
                 $time, ack, ld, sel, imm, PC, Instr_valid, Instr, Fetch_err);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[0] = 32'h8000_0003;
        Reset = 1'b0; PC_Sel = 1'b0; PC_LdEn = 1'b0; PC_Immed = 16'h0;
        imem_ack = 1'b0; imem_rdata = 32'h0;
        model_reset();

        // Reset state, with ack and PC_LdEn wiggling to show they are ignored.
        @(posedge Clk); #1;
        imem_ack = 1'b1; PC_LdEn = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        @(posedge Clk); #1;
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_pc", PC, 32'h0);
        chk("rst_instr", Instr, 32'h0);
        chk("rst_valid", {31'd0, Instr_valid}, 32'd0);
        chk("rst_err", {31'd0, Fetch_err}, 32'd0);
        imem_ack = 1'b0; PC_LdEn = 1'b0;
        Reset = 1'b1;

        // Same-cycle ack, then sequential advance.
        cycle(1'b1, 1'b0, 1'b0, 16'h0);
        chk("first_instr", Instr, 32'h8000_0003);
        chk("first_valid", {31'd0, Instr_valid}, 32'd1);
        cycle(1'b0, 1'b1, 1'b0, 16'h0);
        chk("seq_pc", PC, 32'h4);
        chk("seq_addr", {22'd0, imem_addr}, 32'd1);

        // Delayed ack with PC_LdEn asserted during the wait (ignored), then same-cycle ack+LdEn.
        cycle(1'b0, 1'b1, 1'b1, 16'h7);
        cycle(1'b0, 1'b1, 1'b0, 16'h0);
        cycle(1'b0, 1'b1, 1'b0, 16'h0);
        chk("wait_valid", {31'd0, Instr_valid}, 32'd0);
        chk("wait_pc", PC, 32'h4);
        cycle(1'b1, 1'b1, 1'b0, 16'h0);
        chk("late_pc", PC, 32'h4);
        chk("late_valid", {31'd0, Instr_valid}, 32'd1);

        // Walk to 0x10 and exercise branches, then wrap.
        cycle(1'b0, 1'b1, 1'b0, 16'h0);
        cycle(1'b1, 1'b0, 1'b0, 16'h0);
        cycle(1'b0, 1'b1, 1'b0, 16'h0);
        cycle(1'b1, 1'b0, 1'b0, 16'h0);
        cycle(1'b0, 1'b1, 1'b0, 16'h0);
        chk("at_10", PC, 32'h10);
        cycle(1'b1, 1'b0, 1'b0, 16'h0);
        cycle(1'b0, 1'b1, 1'b1, 16'h0003);
        chk("br_fwd", PC, 32'h20);
        cycle(1'b1, 1'b0, 1'b0, 16'h0);
        cycle(1'b0, 1'b1, 1'b1, 16'hFFFB);
        chk("br_back10", PC, 32'h10);
        cycle(1'b1, 1'b0, 1'b0, 16'h0);
        cycle(1'b0, 1'b1, 1'b1, 16'hFFFC);
        chk("br_neg", PC, 32'h4);
        cycle(1'b1, 1'b0, 1'b0, 16'h0);
        cycle(1'b0, 1'b1, 1'b1, 16'hFFFD);
        chk("at_top", PC, 32'hFFFF_FFFC);
        cycle(1'b1, 1'b0, 1'b0, 16'h0);
        cycle(1'b0, 1'b1, 1'b0, 16'h0);
        chk("wrap_pc", PC, 32'h0);
        chk("wrap_addr", {22'd0, imem_addr}, 32'd0);

        // Reach PC=8 in FETCH, then assert reset between edges.
        cycle(1'b1, 1'b0, 1'b0, 16'h0);
        cycle(1'b0, 1'b1, 1'b0, 16'h0);
        cycle(1'b1, 1'b0, 1'b0, 16'h0);
        cycle(1'b0, 1'b1, 1'b0, 16'h0);
        chk("pre_rst_pc", PC, 32'h8);
        @(negedge Clk);
        imem_ack = 1'b0;
        #2 Reset = 1'b0;
        #1;
        chk("async_req", {31'd0, imem_req}, 32'd0);
        chk("async_pc", PC, 32'h0);
        chk("async_valid", {31'd0, Instr_valid}, 32'd0);
        imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        @(posedge Clk); #1;
        chk("rst_ack_instr", Instr, 32'h0);
        chk("rst_ack_valid", {31'd0, Instr_valid}, 32'd0);
        imem_ack = 1'b0;
        Reset = 1'b1;
        model_reset();

        // Long wait with no ack: watchdog fires if built in, otherwise the stage just waits.
        for (int i = 0; i < TIMEOUT; i++) cycle(1'b0, 1'b0, 1'b0, 16'h0);
`ifdef IF_TIMEOUT_EN
        chk("to_err", {31'd0, Fetch_err}, 32'd1);
        chk("to_gap_req", {31'd0, imem_req}, 32'd0);
`else
        chk("no_to_err", {31'd0, Fetch_err}, 32'd0);
        chk("no_to_req", {31'd0, imem_req}, 32'd1);
`endif
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b0, 16'h0);
        chk("to_pc", PC, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 16'h0);
        chk("to_capture", Instr, mem[0]);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 16'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
